i2c_bus_scheduler: RTL and testbench
====================================

// Module: i2c_bus_scheduler
// PURPOSE
// - Shares one modified-I2C master bus (separate TX/RX lines plus serial clock) among N_REQ requesters.
// - Sequences each read transaction in synthesizable form: 8 address bits out, then 8 data bits in.
// - Arbitration is round-robin; SCLK is derived from the system clock by a divider.
// - Sits between requester logic and the slave_device instances on the shared TX/RX/SCLK wires.
// PARAMETERS
// N_REQ  4  number of requesters (>=2)
// DIV    4  system-clock cycles per SCLK half period (>=1)
// PORTS
// CLK       in   1         system clock; all logic on posedge
// RST       in   1         asynchronous, active-high reset
// REQ       in   N_REQ     request per requester; level, held until DONE
// ADDR_IN   in   8*N_REQ   slave address per requester; byte k = ADDR_IN[8k+7:8k]
// GNT       out  N_REQ     one-hot grant; high for the whole transaction
// DONE      out  N_REQ     one-cycle pulse to the granted requester at completion
// DATA_OUT  out  8         read byte; valid from the DONE cycle, held until the next DONE
// BUSY      out  1         high while a transaction is in progress
// TX        out  1         serial data to slaves (MOSI)
// RX        in   1         serial data from slaves (MISO)
// SCLK      out  1         serial clock to slaves; idles low
// BEHAVIOUR
// - Reset values: GNT=0, DONE=0, DATA_OUT=8'h00, BUSY=0, TX=0, SCLK=0.
// - Reset also clears the state machine to IDLE, rr_ptr to 0, and the bit and divider counters.
// - FSM states:
//   - IDLE: if any REQ bit is high, arbitrate; go to SHIFT at the next edge.
//   - SHIFT: 16 SCLK pulses, bit_cnt 0..15.
//   - FIN: exactly 1 cycle; DONE[g]=1, GNT and BUSY drop; next state IDLE.
// - Arbitration (IDLE):
//   - Winner g = first requester with REQ high, scanning from rr_ptr upward with wrap.
//   - At the same edge: GNT[g]=1, BUSY=1, addr_reg<=ADDR_IN byte g.
//   - At FIN: rr_ptr <= (g+1) mod N_REQ.
// - SCLK timing:
//   - Each pulse = DIV cycles low, then DIV cycles high.
//   - The first low phase starts in the cycle in which GNT rises.
//   - Pulse 0's low phase therefore spans the first DIV SHIFT cycles.
// - Address phase (bit_cnt 0..7):
//   - TX <= addr_reg[bit_cnt] on the first cycle of each low phase, LSB first.
//   - Slaves sample TX on the SCLK rising edge.
// - Data phase (bit_cnt 8..15):
//   - TX <= 0.
//   - RX is sampled into shreg[bit_cnt-8] on the last cycle of the high phase, just before the fall.
//   - A slave updates its TX on the rising edge of the same pulse.
// - Completion:
//   - After the high phase of pulse 15, SCLK returns low and the FSM enters FIN.
//   - DATA_OUT <= shreg at FIN entry.
//   - GNT-rise to DONE pulse = exactly 32*DIV cycles.
//   - Back-to-back: a pending REQ is granted in the cycle after IDLE is re-entered (1 idle cycle minimum).
// - Latency: REQ high in IDLE to GNT high = 1 cycle.
// - Boundaries:
//   - REQ dropped mid-transaction: ignored; the transaction runs to FIN and DONE still pulses.
//   - ADDR_IN changes after grant: ignored, because addr_reg is latched at grant.
//   - Simultaneous requests: only one is granted; the others wait with GNT low.
//   - A requester re-requesting immediately after its DONE loses to any other pending requester.
//   - rr_ptr wraps from N_REQ-1 to 0.
//   - DIV=1: SCLK toggles every cycle; sampling and TX rules are unchanged.
//   - RST mid-transaction: all outputs return to reset values immediately and no DONE is issued.
//     Slaves keep their pulse counters, so the system must reset slaves together with this block.
//   - No ack or timeout: an unmatched address returns whatever RX holds (idle slave TX=0 gives 8'h00).
// STRUCTURE
// - Shared package i2c_sched_pkg:
//   - FSM state encoding IDLE/SHIFT/FIN.
//   - ADDR_BITS=8, DATA_BITS=8, PULSES=16.
// - Sub-module i2c_rr_arbiter:
//   - Inputs: REQ, rr_ptr. Output: one-hot winner index, combinational.
//   - Reused by later bus controllers.
// - Top level holds the FSM, the divider/phase counter, bit_cnt, addr_reg and shreg.
// TESTING (N_REQ=4, DIV=2, slave ADDR=8'hA5, DATA=8'h3C)
// 1 Single request:
//   - Stimulus: REQ=0001, ADDR_IN[7:0]=A5.
//   - TX on the 8 rises = 1,0,1,0,0,1,0,1.
//   - DONE[0] pulses 64 cycles after GNT rises; DATA_OUT=8'h3C.
// 2 Simultaneous requests:
//   - Stimulus: REQ=0101 from reset.
//   - GNT=0001 first; GNT=0100 one cycle after IDLE is re-entered.
//   - REQ[0] re-asserted immediately waits behind requester 2.
// 3 Address mismatch:
//   - Stimulus: requester 1 sends ADDR=8'h5A to a fresh slave.
//   - DATA_OUT=8'h00 and DONE[1] pulses.
// 4 REQ drop:
//   - Stimulus: REQ[3] drops at pulse 5.
//   - Transaction completes; DONE[3] pulses; GNT=0000 afterwards.
// 5 Reset mid-transaction:
//   - Stimulus: RST asserted at pulse 10, slaves reset alike.
//   - Immediately: GNT=0, SCLK=0, TX=0, BUSY=0; no DONE.
//   - A following request reads 8'h3C correctly.
// 6 Fairness:
//   - Stimulus: REQ=1111 held for 8 transactions.
//   - Grant order 0,1,2,3,0,1,2,3.
//   - SCLK pulse count = 16 per transaction.

Source files
------------

// File: rtl/i2c_bus_scheduler_pkg.sv
// Shared constants for the I2C-style bus scheduler: FSM encoding and frame sizes.
package i2c_sched_pkg;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 8;
  localparam int PULSES    = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;
endpackage

// File: rtl/i2c_bus_scheduler_if.sv
// Requester handshake plus shared serial wires. Signal names match the block's port list.
interface i2c_bus_scheduler_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]   REQ;
  logic [8*N_REQ-1:0] ADDR_IN;
  logic [N_REQ-1:0]   GNT;
  logic [N_REQ-1:0]   DONE;
  logic [7:0]         DATA_OUT;
  logic               BUSY;
  logic               TX;
  logic               RX;
  logic               SCLK;

  modport master (input REQ, ADDR_IN, RX,
                  output GNT, DONE, DATA_OUT, BUSY, TX, SCLK);
  modport slave  (output REQ, ADDR_IN, RX,
                  input GNT, DONE, DATA_OUT, BUSY, TX, SCLK);
endinterface

// File: rtl/i2c_bus_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr, wrapping.
module i2c_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] win,
  output logic [PW-1:0]    win_idx,
  output logic             win_any
);
  logic [PW-1:0] j;

  // Scan from the pointer upward; the first hit wins and masks the rest.
  always_comb begin
    win     = '0;
    win_idx = '0;
    win_any = 1'b0;
    j       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = PW'((int'(rr_ptr) + i) % N_REQ);
      if (!win_any && req[j]) begin
        win_any = 1'b1;
        win[j]  = 1'b1;
        win_idx = j;
      end
    end
  end
endmodule

// File: rtl/i2c_bus_scheduler.sv
// Round-robin owner of one serial master bus: 8 address bits out (LSB first),
// then 8 data bits in, with SCLK generated from CLK by a DIV-cycle half period.
module i2c_bus_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIV   = 4
) (
  input  logic                CLK,
  input  logic                RST,
  i2c_bus_scheduler_if.master bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]           state;
  logic [PW-1:0]        rr_ptr, gidx;
  logic [DW-1:0]        div_cnt;
  logic [3:0]           bit_cnt;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [DATA_BITS-1:0] shreg;

  logic [N_REQ-1:0]     gnt, done;
  logic [DATA_BITS-1:0] data_out;
  logic                 busy, tx, sclk;

  logic [N_REQ-1:0]     win_oh;
  logic [PW-1:0]        win_idx;
  logic                 win_any;
  logic [ADDR_BITS-1:0] sel_addr;
  logic                 last_tick;

  i2c_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req     (bus.REQ),
    .rr_ptr  (rr_ptr),
    .win     (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Winner's address byte and end-of-half-period strobe.
  always_comb begin
    sel_addr  = bus.ADDR_IN[int'(win_idx)*8 +: 8];
    last_tick = (div_cnt == DW'(DIV - 1));
  end

  // Transaction FSM, SCLK divider, shift registers and outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gidx     <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      addr_reg <= '0;
      shreg    <= '0;
      gnt      <= '0;
      done     <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      tx       <= 1'b0;
      sclk     <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_any) begin
            gnt      <= win_oh;
            busy     <= 1'b1;
            gidx     <= win_idx;
            addr_reg <= sel_addr;
            // Pulse 0's low phase begins with the grant, so bit 0 goes out now
            // straight from the input rather than from addr_reg.
            tx       <= sel_addr[0];
            sclk     <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_tick) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt >= 4'(ADDR_BITS)) shreg[bit_cnt[2:0]] <= bus.RX;
              if (bit_cnt == 4'(PULSES - 1)) begin
                // Last bit is captured in this same edge, so fold it in directly.
                data_out <= {bus.RX, shreg[DATA_BITS-2:0]};
                done     <= gnt;
                gnt      <= '0;
                busy     <= 1'b0;
                tx       <= 1'b0;
                state    <= FIN;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                tx      <= (bit_cnt < 4'(ADDR_BITS - 1)) ? addr_reg[bit_cnt[2:0] + 3'd1] : 1'b0;
              end
            end
          end
        end
        FIN: begin
          rr_ptr <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.GNT      = gnt;
  assign bus.DONE     = done;
  assign bus.DATA_OUT = data_out;
  assign bus.BUSY     = busy;
  assign bus.TX       = tx;
  assign bus.SCLK     = sclk;
endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Directed bench: one DUT (N_REQ=4, DIV=2) plus a behavioural slave at 8'hA5 returning 8'h3C.
module tb_i2c_bus_scheduler;
  localparam int N_REQ = 4;
  localparam int DIV   = 2;
  localparam int TMO   = 1000;

  logic CLK = 1'b0;
  logic RST;
  int   vecs = 0;
  int   errs = 0;

  i2c_bus_scheduler_if #(.N_REQ(N_REQ)) bus();

  i2c_bus_scheduler #(.N_REQ(N_REQ), .DIV(DIV)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  // Slave: samples address on rises 0..7, drives data bits LSB first on rises 8..15 if addressed.
  logic [3:0] spc;
  logic [7:0] s_addr;
  logic       miso;
  logic [7:0] slv_data;
  int         sclk_rises = 0;

  always @(posedge bus.SCLK or posedge RST) begin
    if (RST) begin
      spc    <= 4'd0;
      s_addr <= 8'h00;
      miso   <= 1'b0;
    end else begin
      if (!spc[3]) s_addr[spc[2:0]] <= bus.TX;
      else         miso <= (s_addr == 8'hA5) ? slv_data[spc[2:0]] : 1'b0;
      spc <= spc + 4'd1;
    end
  end

  always @(posedge bus.SCLK) sclk_rises <= sclk_rises + 1;

  assign bus.RX = miso;

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.DONE === 4'b0000 && cyc < TMO) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    while (bus.GNT === 4'b0000 && cyc < TMO) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic wait_rises(input int base, input int n);
    int c;
    c = 0;
    while (sclk_rises - base < n && c < TMO) begin
      @(negedge CLK);
      c++;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.REQ = 4'b0000;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    vecs++; if (bus.GNT !== 4'b0000) begin errs++; $display("FAIL rst_gnt: got %b want 0000", bus.GNT); end
    vecs++; if (bus.DONE !== 4'b0000) begin errs++; $display("FAIL rst_done: got %b want 0000", bus.DONE); end
    vecs++; if (bus.DATA_OUT !== 8'h00) begin errs++; $display("FAIL rst_data: got %h want 00", bus.DATA_OUT); end
    vecs++; if (bus.BUSY !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", bus.BUSY); end
    vecs++; if (bus.TX !== 1'b0) begin errs++; $display("FAIL rst_tx: got %b want 0", bus.TX); end
    vecs++; if (bus.SCLK !== 1'b0) begin errs++; $display("FAIL rst_sclk: got %b want 0", bus.SCLK); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    int cyc, base;
    bus.ADDR_IN = {8'h00, 8'h00, 8'h00, 8'hA5};
    bus.REQ = 4'b0001;
    base = sclk_rises;
    @(negedge CLK);
    vecs++; if (bus.GNT !== 4'b0001) begin errs++; $display("FAIL single_gnt_latency: got %b want 0001", bus.GNT); end
    vecs++; if (bus.BUSY !== 1'b1) begin errs++; $display("FAIL single_busy: got %b want 1", bus.BUSY); end
    wait_done(cyc);
    vecs++; if (cyc !== 64) begin errs++; $display("FAIL single_done_latency: got %0d want 64", cyc); end
    vecs++; if (bus.DONE !== 4'b0001) begin errs++; $display("FAIL single_done: got %b want 0001", bus.DONE); end
    vecs++; if (bus.DATA_OUT !== 8'h3C) begin errs++; $display("FAIL single_data: got %h want 3c", bus.DATA_OUT); end
    vecs++; if (s_addr !== 8'hA5) begin errs++; $display("FAIL single_tx_addr: got %h want a5", s_addr); end
    vecs++; if (sclk_rises - base !== 16) begin errs++; $display("FAIL single_pulses: got %0d want 16", sclk_rises - base); end
    vecs++; if (bus.GNT !== 4'b0000) begin errs++; $display("FAIL single_gnt_fin: got %b want 0000", bus.GNT); end
    bus.REQ = 4'b0000;
    @(negedge CLK);
    vecs++; if (bus.DONE !== 4'b0000) begin errs++; $display("FAIL single_done_pulse: got %b want 0000", bus.DONE); end
    vecs++; if (bus.DATA_OUT !== 8'h3C) begin errs++; $display("FAIL single_data_hold: got %h want 3c", bus.DATA_OUT); end
  endtask

  task automatic test_simultaneous();
    int cyc;
    do_reset();
    bus.ADDR_IN = {8'h00, 8'hA5, 8'h00, 8'hA5};
    bus.REQ = 4'b0101;
    @(negedge CLK);
    vecs++; if (bus.GNT !== 4'b0001) begin errs++; $display("FAIL simul_first: got %b want 0001", bus.GNT); end
    wait_done(cyc);
    vecs++; if (bus.DONE !== 4'b0001) begin errs++; $display("FAIL simul_done0: got %b want 0001", bus.DONE); end
    @(negedge CLK);
    vecs++; if (bus.GNT !== 4'b0000) begin errs++; $display("FAIL simul_idle_gap: got %b want 0000", bus.GNT); end
    @(negedge CLK);
    vecs++; if (bus.GNT !== 4'b0100) begin errs++; $display("FAIL simul_second: got %b want 0100", bus.GNT); end
    wait_done(cyc);
    vecs++; if (bus.DONE !== 4'b0100) begin errs++; $display("FAIL simul_done2: got %b want 0100", bus.DONE); end
    bus.REQ = 4'b0001;
    wait_gnt(cyc);
    vecs++; if (bus.GNT !== 4'b0001) begin errs++; $display("FAIL simul_rerequest: got %b want 0001", bus.GNT); end
    wait_done(cyc);
    vecs++; if (bus.DATA_OUT !== 8'h3C) begin errs++; $display("FAIL simul_data: got %h want 3c", bus.DATA_OUT); end
    bus.REQ = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_mismatch();
    int cyc;
    bus.ADDR_IN = {8'h00, 8'h00, 8'h5A, 8'h00};
    bus.REQ = 4'b0010;
    wait_gnt(cyc);
    vecs++; if (bus.GNT !== 4'b0010) begin errs++; $display("FAIL mism_gnt: got %b want 0010", bus.GNT); end
    wait_done(cyc);
    vecs++; if (bus.DONE !== 4'b0010) begin errs++; $display("FAIL mism_done: got %b want 0010", bus.DONE); end
    vecs++; if (bus.DATA_OUT !== 8'h00) begin errs++; $display("FAIL mism_data: got %h want 00", bus.DATA_OUT); end
    vecs++; if (s_addr !== 8'h5A) begin errs++; $display("FAIL mism_tx_addr: got %h want 5a", s_addr); end
    bus.REQ = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_req_drop();
    int cyc, base;
    bus.ADDR_IN = {8'hA5, 8'h00, 8'h00, 8'h00};
    bus.REQ = 4'b1000;
    wait_gnt(cyc);
    vecs++; if (bus.GNT !== 4'b1000) begin errs++; $display("FAIL drop_gnt: got %b want 1000", bus.GNT); end
    // Address change after grant must not affect the frame.
    bus.ADDR_IN = {8'h5A, 8'h00, 8'h00, 8'h00};
    base = sclk_rises;
    wait_rises(base, 5);
    bus.REQ = 4'b0000;
    wait_done(cyc);
    vecs++; if (bus.DONE !== 4'b1000) begin errs++; $display("FAIL drop_done: got %b want 1000", bus.DONE); end
    vecs++; if (bus.DATA_OUT !== 8'h3C) begin errs++; $display("FAIL drop_data: got %h want 3c", bus.DATA_OUT); end
    repeat (5) @(negedge CLK);
    vecs++; if (bus.GNT !== 4'b0000) begin errs++; $display("FAIL drop_gnt_after: got %b want 0000", bus.GNT); end
    vecs++; if (bus.BUSY !== 1'b0) begin errs++; $display("FAIL drop_busy_after: got %b want 0", bus.BUSY); end
  endtask

  task automatic test_reset_mid();
    int cyc, base;
    bus.ADDR_IN = {8'h00, 8'h00, 8'h00, 8'hA5};
    bus.REQ = 4'b0001;
    wait_gnt(cyc);
    base = sclk_rises;
    wait_rises(base, 10);
    RST = 1'b1;
    #1;
    vecs++; if (bus.GNT !== 4'b0000) begin errs++; $display("FAIL rmid_gnt: got %b want 0000", bus.GNT); end
    vecs++; if (bus.SCLK !== 1'b0) begin errs++; $display("FAIL rmid_sclk: got %b want 0", bus.SCLK); end
    vecs++; if (bus.TX !== 1'b0) begin errs++; $display("FAIL rmid_tx: got %b want 0", bus.TX); end
    vecs++; if (bus.BUSY !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b want 0", bus.BUSY); end
    repeat (3) @(negedge CLK);
    vecs++; if (bus.DONE !== 4'b0000) begin errs++; $display("FAIL rmid_no_done: got %b want 0000", bus.DONE); end
    RST = 1'b0;
    @(negedge CLK);
    vecs++; if (bus.GNT !== 4'b0001) begin errs++; $display("FAIL rmid_regrant: got %b want 0001", bus.GNT); end
    wait_done(cyc);
    vecs++; if (cyc !== 64) begin errs++; $display("FAIL rmid_latency: got %0d want 64", cyc); end
    vecs++; if (bus.DATA_OUT !== 8'h3C) begin errs++; $display("FAIL rmid_data: got %h want 3c", bus.DATA_OUT); end
    bus.REQ = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_fairness();
    int cyc, base;
    logic [3:0] exp;
    do_reset();
    bus.ADDR_IN = {8'hA5, 8'hA5, 8'hA5, 8'hA5};
    bus.REQ = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_gnt(cyc);
      exp = 4'(1 << (t % 4));
      base = sclk_rises;
      vecs++; if (bus.GNT !== exp) begin errs++; $display("FAIL fair_gnt_%0d: got %b want %b", t, bus.GNT, exp); end
      wait_done(cyc);
      vecs++; if (bus.DONE !== exp) begin errs++; $display("FAIL fair_done_%0d: got %b want %b", t, bus.DONE, exp); end
      vecs++; if (sclk_rises - base !== 16) begin errs++; $display("FAIL fair_pulses_%0d: got %0d want 16", t, sclk_rises - base); end
      vecs++; if (bus.DATA_OUT !== 8'h3C) begin errs++; $display("FAIL fair_data_%0d: got %h want 3c", t, bus.DATA_OUT); end
    end
    bus.REQ = 4'b0000;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    bus.REQ = 4'b0000;
    bus.ADDR_IN = '0;
    slv_data = 8'h3C;
    test_reset();
    test_single();
    test_simultaneous();
    test_mismatch();
    test_req_drop();
    test_reset_mid();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
